// File: rtl/miriscv_pkg.sv
// Shared definitions for the miriscv core: datapath width, reset/NOP constants and
// the fetch-buffer entry layout.
package miriscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/miriscv_fetch_unit_if.sv
// Fetch stage connections: req/gnt/rvalid instruction-memory bus, redirect input and
// the valid/ready decode interface. The fetch unit is the master side.
interface miriscv_fetch_unit_if;
  import miriscv_pkg::*;

  logic            instr_req_o;
  logic [XLEN-1:0] instr_addr_o;
  logic            instr_gnt_i;
  logic            instr_rvalid_i;
  logic [XLEN-1:0] instr_rdata_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            fetch_valid_o;
  logic            fetch_ready_i;
  logic [XLEN-1:0] fetch_instr_o;
  logic [XLEN-1:0] fetch_pc_o;

  modport master (
    output instr_req_o, instr_addr_o, fetch_valid_o, fetch_instr_o, fetch_pc_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, redirect_i, redirect_pc_i,
           fetch_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o, fetch_valid_o, fetch_instr_o, fetch_pc_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, redirect_i, redirect_pc_i,
           fetch_ready_i
  );

endinterface

// File: rtl/miriscv_sync_fifo.sv
// Synchronous FIFO with synchronous flush and occupancy count; pointers wrap explicitly
// at DEPTH so non-power-of-2 depths work.
module miriscv_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which words are meaningful.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assert property (@(posedge clk_i) disable iff (!arstn_i)
    !(push && !flush && (count == CW'(DEPTH)) && !do_pop));

endmodule

// File: rtl/miriscv_fetch_unit.sv
// Instruction fetch stage: credit-limited req/gnt/rvalid issue, in-order PC queue,
// prefetch buffer toward decode, and redirect with discard of in-flight responses.
module miriscv_fetch_unit
  import miriscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input logic                 clk_i,
  input logic                 arstn_i,
  miriscv_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;

  logic            started;
  logic            req_pending;
  logic            jump_vld;
  logic [XLEN-1:0] jump_pc;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target_pc;
  cnt_t            outstanding;
  cnt_t            discard;
  cnt_t            outstanding_nxt;
  cnt_t            discard_nxt;
  cnt_t            buf_count;
  cnt_t            pcq_count;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t    buf_wdata;
  fetch_entry_t    buf_head;
  logic            buf_empty;
  logic            credit_ok;
  logic            req;
  logic            grant;
  logic            rsp;
  logic            rsp_keep;

  // Buffered entries plus in-flight requests never exceed DEPTH, so every grant owns a slot.
  assign credit_ok = ({1'b0, buf_count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
  assign req       = started && (credit_ok || req_pending);
  assign grant     = req && bus.instr_gnt_i;
  // An rvalid with nothing outstanding is a leftover from before reset.
  assign rsp       = bus.instr_rvalid_i && (outstanding != '0);
  assign rsp_keep  = rsp && (discard == '0) && !bus.redirect_i;
  assign target_pc = {bus.redirect_pc_i[XLEN-1:2], 2'b00};

  assign outstanding_nxt = outstanding + cnt_t'(grant) - cnt_t'(rsp);
  assign discard_nxt     = discard - cnt_t'(rsp && (discard != '0));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      started     <= 1'b0;
      req_pending <= 1'b0;
      jump_vld    <= 1'b0;
      jump_pc     <= RESET_PC;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      started     <= 1'b1;
      req_pending <= req && !bus.instr_gnt_i;
      outstanding <= outstanding_nxt;
      if (bus.redirect_i) begin
        discard <= outstanding_nxt;
        // An ungranted request must stay on the bus; the jump is parked until it is granted.
        if (req && !bus.instr_gnt_i) begin
          jump_vld <= 1'b1;
          jump_pc  <= target_pc;
        end else begin
          jump_vld <= 1'b0;
          fetch_pc <= target_pc;
        end
      end else if (grant && jump_vld) begin
        discard  <= discard_nxt + cnt_t'(1);
        jump_vld <= 1'b0;
        fetch_pc <= jump_pc;
      end else begin
        discard <= discard_nxt;
        if (grant) fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  miriscv_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush   (bus.redirect_i),
    .push    (grant && !jump_vld),
    .wdata   (fetch_pc),
    .pop     (rsp_keep),
    .rdata   (pcq_head),
    .count   (pcq_count)
  );

  assign buf_wdata = '{instr: bus.instr_rdata_i, pc: pcq_head};

  miriscv_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fetch_buf (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush   (bus.redirect_i),
    .push    (rsp_keep),
    .wdata   (buf_wdata),
    .pop     (!buf_empty && bus.fetch_ready_i),
    .rdata   (buf_head),
    .count   (buf_count)
  );

  assign buf_empty         = (buf_count == '0);
  assign bus.instr_req_o   = req;
  assign bus.instr_addr_o  = fetch_pc;
  assign bus.fetch_valid_o = !buf_empty;
  assign bus.fetch_instr_o = buf_empty ? '0 : buf_head.instr;
  assign bus.fetch_pc_o    = buf_empty ? '0 : buf_head.pc;

  assert property (@(posedge clk_i) disable iff (!arstn_i)
    (int'(buf_count) + int'(outstanding)) <= DEPTH);
  assert property (@(posedge clk_i) disable iff (!arstn_i)
    (int'(pcq_count) + int'(discard)) == int'(outstanding));

endmodule

// File: tb/tb_miriscv_fetch_unit.sv
// Directed bench for miriscv_fetch_unit: in-order memory responder plus hand-computed
// addresses, PCs and instruction words.
module tb_miriscv_fetch_unit;
  import miriscv_pkg::*;

  logic clk_i = 1'b0;
  logic arstn_i;
  always #5 clk_i = ~clk_i;

  miriscv_fetch_unit_if bus();

  miriscv_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rsp_q[$];
  logic [31:0] gnt_log[$];
  logic        rsp_en;
  int          base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  // One clock: record a grant, then drive the in-order response on the following cycle.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    g = bus.instr_req_o && bus.instr_gnt_i;
    a = bus.instr_addr_o;
    @(posedge clk_i);
    if (g) begin
      rsp_q.push_back(a);
      gnt_log.push_back(a);
    end
    @(negedge clk_i);
    if (rsp_en && rsp_q.size() > 0) begin
      bus.instr_rvalid_i = 1'b1;
      bus.instr_rdata_i  = mem_word(rsp_q.pop_front());
    end else begin
      bus.instr_rvalid_i = 1'b0;
      bus.instr_rdata_i  = '0;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.fetch_valid_o && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, bus.fetch_valid_o, 1);
  endtask

  task automatic wait_grants(input string tag, input int cnt, input int budget);
    int n = 0;
    while (gnt_log.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_grants"}, gnt_log.size(), cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   bus.instr_req_o,   0);
    check({tag, "_addr"},  bus.instr_addr_o,  32'h0);
    check({tag, "_valid"}, bus.fetch_valid_o, 0);
    check({tag, "_instr"}, bus.fetch_instr_o, 32'h0);
    check({tag, "_pc"},    bus.fetch_pc_o,    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    arstn_i            = 1'b0;
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i  = '0;
    bus.redirect_i     = 1'b0;
    bus.redirect_pc_i  = '0;
    bus.fetch_ready_i  = 1'b0;
    rsp_en             = 1'b1;
    repeat (2) @(negedge clk_i);
    check_reset_outputs("rst");

    // 1: reset release, gnt tied high, response one cycle after grant
    bus.instr_gnt_i = 1'b1;
    arstn_i         = 1'b1;
    tick();
    check("t1_req", bus.instr_req_o, 1);
    check("t1_addr", bus.instr_addr_o, 32'h0);
    tick();
    check("t1_valid_n1", bus.fetch_valid_o, 0);
    tick();
    check("t1_valid_n2", bus.fetch_valid_o, 1);
    check("t1_pc", bus.fetch_pc_o, 32'h0);
    check("t1_instr", bus.fetch_instr_o, 32'h0000_0013);

    // 2: decode stalled, credit stops issue after four grants
    repeat (5) tick();
    check("t2_req_off", bus.instr_req_o, 0);
    check("t2_grants", gnt_log.size(), 4);
    check("t2_addr1", gnt_log[1], 32'h4);
    check("t2_addr2", gnt_log[2], 32'h8);
    check("t2_addr3", gnt_log[3], 32'hC);
    bus.fetch_ready_i = 1'b1;
    tick();
    bus.fetch_ready_i = 1'b0;
    repeat (4) tick();
    check("t2_one_more", gnt_log.size(), 5);
    check("t2_addr4", gnt_log[4], 32'h10);
    check("t2_req_off2", bus.instr_req_o, 0);
    check("t2_head_pc", bus.fetch_pc_o, 32'h4);
    check("t2_head_instr", bus.fetch_instr_o, 32'h0004_0013);

    // 3: gnt withheld for five cycles
    bus.instr_gnt_i   = 1'b0;
    bus.fetch_ready_i = 1'b1;
    tick();
    bus.fetch_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_req_c%0d", i), bus.instr_req_o, 1);
      check($sformatf("t3_addr_c%0d", i), bus.instr_addr_o, 32'h14);
      tick();
    end
    check("t3_outstanding", 32'(dut.outstanding), 0);
    check("t3_no_grant", gnt_log.size(), 5);
    bus.instr_gnt_i = 1'b1;
    repeat (2) tick();
    check("t3_granted", gnt_log[5], 32'h14);
    check("t3_req_off", bus.instr_req_o, 0);

    // 4: redirect with two responses outstanding
    rsp_en            = 1'b0;
    bus.fetch_ready_i = 1'b1;
    repeat (2) tick();
    bus.fetch_ready_i = 1'b0;
    tick();
    check("t4_credit_full", bus.instr_req_o, 0);
    check("t4_outstanding", 32'(dut.outstanding), 2);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0104;
    tick();
    bus.redirect_i = 1'b0;
    rsp_en         = 1'b1;
    check("t4_flushed", bus.fetch_valid_o, 0);
    check("t4_req", bus.instr_req_o, 1);
    check("t4_addr", bus.instr_addr_o, 32'h104);
    wait_valid("t4", 12);
    check("t4_pc", bus.fetch_pc_o, 32'h104);
    check("t4_instr", bus.fetch_instr_o, 32'h0104_0013);
    repeat (6) tick();

    // 5: redirect while a request is pending ungranted
    bus.instr_gnt_i   = 1'b0;
    bus.fetch_ready_i = 1'b1;
    tick();
    bus.fetch_ready_i = 1'b0;
    check("t5_pend_req", bus.instr_req_o, 1);
    check("t5_pend_addr", bus.instr_addr_o, 32'h114);
    base              = gnt_log.size();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0203;
    tick();
    bus.redirect_i = 1'b0;
    check("t5_hold_req", bus.instr_req_o, 1);
    check("t5_hold_addr", bus.instr_addr_o, 32'h114);
    check("t5_flushed", bus.fetch_valid_o, 0);
    tick();
    check("t5_hold_addr2", bus.instr_addr_o, 32'h114);
    bus.instr_gnt_i = 1'b1;
    tick();
    check("t5_new_req", bus.instr_req_o, 1);
    check("t5_new_addr", bus.instr_addr_o, 32'h200);
    tick();
    check("t5_old_granted", gnt_log[base], 32'h114);
    check("t5_new_granted", gnt_log[base + 1], 32'h200);
    wait_valid("t5", 12);
    check("t5_pc", bus.fetch_pc_o, 32'h200);
    check("t5_instr", bus.fetch_instr_o, 32'h0200_0013);

    // 6: PC wrap, reset mid-burst, stale response after release
    bus.fetch_ready_i = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    tick();
    bus.redirect_i = 1'b0;
    gnt_log.delete();
    wait_grants("t6", 3, 12);
    check("t6_addr0", gnt_log[0], 32'hFFFF_FFF8);
    check("t6_addr1", gnt_log[1], 32'hFFFF_FFFC);
    check("t6_addr2", gnt_log[2], 32'h0);
    arstn_i = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    rsp_q.delete();
    bus.instr_gnt_i    = 1'b0;
    bus.fetch_ready_i  = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    @(negedge clk_i);
    arstn_i            = 1'b1;
    bus.instr_rvalid_i = 1'b1;
    bus.instr_rdata_i  = 32'hDEAD_BEEF;
    tick();
    bus.instr_rvalid_i = 1'b1;
    bus.instr_rdata_i  = 32'hDEAD_BEEF;
    tick();
    check("t6_stale_valid", bus.fetch_valid_o, 0);
    check("t6_stale_req", bus.instr_req_o, 1);
    check("t6_stale_addr", bus.instr_addr_o, 32'h0);
    bus.instr_gnt_i = 1'b1;
    wait_valid("t6", 10);
    check("t6_pc", bus.fetch_pc_o, 32'h0);
    check("t6_instr", bus.fetch_instr_o, 32'h0000_0013);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
